present_sequencer: RTL and testbench

- Transaction controller placed directly upstream of the PRESENT-80 core.
- Accepts one encrypt/decrypt request per valid/ready handshake and drives the core's reset, key, block and enc_dec inputs.
- Waits for key generation and then the relevant completion flag, captures the core output and returns it with a cycle count over a valid/ready response channel.
- Lets the autotest harness, or any bus front-end, run back-to-back operations without hand-sequencing the core reset.

---
 rtl/present_seq_pkg.sv | 22 ++
 rtl/present_sequencer_sat_counter.sv | 38 +++
 rtl/present_sequencer.sv | 153 +++++++++++++++
 tb/tb_present_sequencer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/present_seq_pkg.sv
// Shared types for the PRESENT-80 transaction sequencer.
// Holds the FSM encoding and the latched request bundle.
package present_seq_pkg;

  localparam int KEY_W = 80;
  localparam int BLK_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    CORE_RST,
    KEYGEN,
    CRYPT,
    RESP
  } seq_state_t;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [BLK_W-1:0] block;
    logic             enc_dec;
  } req_t;

endpackage

// File: rtl/present_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Used as the latency / timeout counter of the sequencer.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_o = cnt_q;
  assign sat_o = &cnt_q;

  // Next count: clear wins, otherwise count up and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !sat_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/present_sequencer.sv
// Request/response sequencer in front of a PRESENT-80 core.
// Pulses core reset, waits for key schedule and done, returns result.
module present_sequencer
  import present_seq_pkg::*;
#(
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [KEY_W-1:0] key_i,
  input  logic [BLK_W-1:0] block_i,
  input  logic             enc_dec_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [BLK_W-1:0] block_o,
  output logic [CNT_W-1:0] cycles_o,
  output logic             timeout_o,
  output logic             core_rst_o,
  output logic [KEY_W-1:0] core_key_o,
  output logic [BLK_W-1:0] core_block_o,
  output logic             core_enc_dec_o,
  input  logic             core_end_key_i,
  input  logic [BLK_W-1:0] core_block_i,
  input  logic             core_end_enc_i,
  input  logic             core_end_dec_i
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYCLES);

  seq_state_t       state_q, state_d;
  logic [RW-1:0]    rcnt_q, rcnt_d;
  req_t             req_q, req_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             to_q, to_d;
  logic [CNT_W-1:0] lat_cnt, lat_p1;
  logic             lat_clr, lat_en, lat_sat;
  logic             done, at_limit;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_lat (
    .clk   (clk),
    .rst   (rst),
    .clr   (lat_clr),
    .en    (lat_en),
    .cnt_o (lat_cnt),
    .sat_o (lat_sat)
  );

  assign done     = req_q.enc_dec ? core_end_enc_i : core_end_dec_i;
  assign at_limit = (lat_cnt == TO_LAST);
  assign lat_p1   = lat_sat ? lat_cnt : lat_cnt + CNT_W'(1);

  assign req_ready_o    = (state_q == IDLE);
  assign resp_valid_o   = (state_q == RESP);
  assign core_rst_o     = !((state_q == KEYGEN) || (state_q == CRYPT));
  assign core_key_o     = req_q.key;
  assign core_block_o   = req_q.block;
  assign core_enc_dec_o = req_q.enc_dec;
  assign block_o        = blk_q;
  assign cycles_o       = cyc_q;
  assign timeout_o      = to_q;

  // Next-state, request capture and response capture.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    req_d   = req_q;
    blk_d   = blk_q;
    cyc_d   = cyc_q;
    to_d    = to_q;
    lat_clr = 1'b0;
    lat_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          req_d.key     = key_i;
          req_d.block   = block_i;
          req_d.enc_dec = enc_dec_i;
          rcnt_d        = RST_LOAD;
          state_d       = CORE_RST;
        end
      end
      CORE_RST: begin
        if (rcnt_q == '0) begin
          lat_clr = 1'b1;
          state_d = KEYGEN;
        end else begin
          rcnt_d = rcnt_q - RW'(1);
        end
      end
      KEYGEN: begin
        lat_en = 1'b1;
        if (at_limit) begin
          blk_d   = '0;
          cyc_d   = TO_VAL;
          to_d    = 1'b1;
          state_d = RESP;
        end else if (core_end_key_i) begin
          state_d = CRYPT;
        end
      end
      CRYPT: begin
        lat_en = 1'b1;
        if (done) begin
          blk_d   = core_block_i;
          cyc_d   = lat_p1;
          to_d    = 1'b0;
          state_d = RESP;
        end else if (at_limit) begin
          blk_d   = '0;
          cyc_d   = TO_VAL;
          to_d    = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      req_q   <= '0;
      blk_q   <= '0;
      cyc_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      req_q   <= req_d;
      blk_q   <= blk_d;
      cyc_q   <= cyc_d;
      to_q    <= to_d;
    end
  end

endmodule

// File: tb/tb_present_sequencer.sv
// Bench for present_sequencer with an emulated PRESENT-80 core.
// Results and timing are predicted from the protocol rules.
module tb_present_sequencer;

  localparam int TO  = 64;
  localparam int RSC = 2;
  localparam logic [63:0] SBOX = 64'h21748FE3DA09B65C;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_ready_o;
  logic [79:0] key_i;
  logic [63:0] block_i;
  logic        enc_dec_i;
  logic        resp_valid_o, resp_ready_i;
  logic [63:0] block_o;
  logic [31:0] cycles_o;
  logic        timeout_o;
  logic        core_rst_o;
  logic [79:0] core_key_o;
  logic [63:0] core_block_o;
  logic        core_enc_dec_o;
  logic        core_end_key_i;
  logic [63:0] core_block_i;
  logic        core_end_enc_i, core_end_dec_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [79:0] key;
    logic [63:0] blk;
    logic        enc;
    logic [63:0] rblk;
    logic [31:0] cyc;
    logic        to;
  } exp_t;

  exp_t exp_q[$];

  present_sequencer #(
    .RST_CYCLES     (RSC),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .key_i          (key_i),
    .block_i        (block_i),
    .enc_dec_i      (enc_dec_i),
    .resp_valid_o   (resp_valid_o),
    .resp_ready_i   (resp_ready_i),
    .block_o        (block_o),
    .cycles_o       (cycles_o),
    .timeout_o      (timeout_o),
    .core_rst_o     (core_rst_o),
    .core_key_o     (core_key_o),
    .core_block_o   (core_block_o),
    .core_enc_dec_o (core_enc_dec_o),
    .core_end_key_i (core_end_key_i),
    .core_block_i   (core_block_i),
    .core_end_enc_i (core_end_enc_i),
    .core_end_dec_i (core_end_dec_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- PRESENT-80 reference ----------------
  function automatic logic [3:0] sb(input logic [3:0] x);
    logic [63:0] t;
    t = SBOX;
    return t[x*4 +: 4];
  endfunction

  function automatic logic [3:0] isb(input logic [3:0] x);
    logic [3:0] r;
    r = '0;
    for (int j = 0; j < 16; j++)
      if (sb(4'(j)) == x) r = 4'(j);
    return r;
  endfunction

  function automatic logic [63:0] sbl(input logic [63:0] s, input bit inv);
    logic [63:0] r;
    for (int j = 0; j < 16; j++)
      r[j*4 +: 4] = inv ? isb(s[j*4 +: 4]) : sb(s[j*4 +: 4]);
    return r;
  endfunction

  function automatic logic [63:0] pl(input logic [63:0] s, input bit inv);
    logic [63:0] r;
    r[63] = s[63];
    for (int j = 0; j < 63; j++)
      if (inv) r[j] = s[(j*16) % 63];
      else     r[(j*16) % 63] = s[j];
    return r;
  endfunction

  function automatic logic [79:0] nk(input logic [79:0] k, input int i);
    logic [79:0] r;
    r = {k[18:0], k[79:19]};
    r[79:76] = sb(r[79:76]);
    r[19:15] = r[19:15] ^ 5'(i);
    return r;
  endfunction

  function automatic logic [63:0] p_enc(input logic [79:0] key,
                                        input logic [63:0] pt);
    logic [63:0] s;
    logic [79:0] k;
    s = pt;
    k = key;
    for (int i = 1; i <= 31; i++) begin
      s = pl(sbl(s ^ k[79:16], 1'b0), 1'b0);
      k = nk(k, i);
    end
    return s ^ k[79:16];
  endfunction

  function automatic logic [63:0] p_dec(input logic [79:0] key,
                                        input logic [63:0] ct);
    logic [63:0] rk [32];
    logic [63:0] s;
    logic [79:0] k;
    k = key;
    rk[0] = k[79:16];
    for (int i = 1; i <= 31; i++) begin
      k = nk(k, i);
      rk[i] = k[79:16];
    end
    s = ct ^ rk[31];
    for (int i = 30; i >= 0; i--)
      s = sbl(pl(s, 1'b1), 1'b1) ^ rk[i];
    return s;
  endfunction

  // ---------------- emulated core ----------------
  int          st_kl = 2;
  int          st_cl = 2;
  bit          st_never = 1'b0;
  int          age = 0;
  logic [63:0] res = '0;
  logic [63:0] garb = '0;
  logic        n_a = 1'b0;
  logic        n_b = 1'b0;
  logic        done_lvl;

  always @(posedge clk) begin
    age  <= core_rst_o ? 0 : age + 1;
    n_a  <= 1'($urandom_range(0, 1));
    n_b  <= 1'($urandom_range(0, 1));
    garb <= {$urandom, $urandom};
    if (core_rst_o === 1'b1)
      res <= core_enc_dec_o ? p_enc(core_key_o, core_block_o)
                            : p_dec(core_key_o, core_block_o);
  end

  assign done_lvl = !core_rst_o && !st_never && (age >= st_kl + st_cl);
  assign core_end_key_i = !core_rst_o && (age >= st_kl);
  assign core_end_enc_i = core_enc_dec_o ? done_lvl : n_a;
  assign core_end_dec_i = core_enc_dec_o ? n_b : done_lvl;
  assign core_block_i   = done_lvl ? res : garb;

  // ---------------- behavioural model ----------------
  // Done is first seen in the cycle after key-end at the earliest;
  // cycles are counted from core reset release, inclusive of done.
  function automatic exp_t model(input logic [79:0] k, input logic [63:0] b,
                                 input logic e, input int kl, input int cl,
                                 input bit nev);
    exp_t m;
    int c;
    m.key = k;
    m.blk = b;
    m.enc = e;
    c = nev ? (1 << 30) : ((cl < 1) ? kl + 1 : kl + cl);
    if (c > TO - 1) begin
      m.rblk = '0;
      m.cyc  = 32'(TO);
      m.to   = 1'b1;
    end else begin
      m.rblk = e ? p_enc(k, b) : p_dec(k, b);
      m.cyc  = 32'(c + 1);
      m.to   = 1'b0;
    end
    return m;
  endfunction

  // ---------------- compare process ----------------
  int cyc = 0;
  int t_rel = 0;
  bit busy = 1'b0;
  bit p_rst = 1'b0;
  bit p_rv = 1'b0;
  bit p_crst = 1'b1;

  initial forever begin
    @(negedge clk);
    #1;
    cyc++;
    if (p_rst) begin
      chk("rst_req_ready", req_ready_o, 1);
      chk("rst_resp_valid", resp_valid_o, 0);
      chk("rst_timeout", timeout_o, 0);
      chk("rst_block", block_o, 0);
      chk("rst_cycles", cycles_o, 0);
      chk("rst_core_rst", core_rst_o, 1);
      chk("rst_core_key", core_key_o, 0);
      chk("rst_core_block", core_block_o, 0);
      chk("rst_core_enc", core_enc_dec_o, 0);
    end
    if (!rst) begin
      chk("req_ready", req_ready_o, !busy);
      if (resp_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("spurious_resp", resp_valid_o, 0);
        end else begin
          chk("resp_block", block_o, exp_q[0].rblk);
          chk("resp_cycles", cycles_o, exp_q[0].cyc);
          chk("resp_timeout", timeout_o, exp_q[0].to);
          if (!p_rv) chk("latency", 32'(cyc - t_rel), exp_q[0].cyc);
        end
      end
      if (!core_rst_o && exp_q.size() != 0) begin
        chk("core_key", core_key_o, exp_q[0].key);
        chk("core_block", core_block_o, exp_q[0].blk);
        chk("core_enc", core_enc_dec_o, exp_q[0].enc);
      end
      if (!core_rst_o && p_crst) t_rel = cyc;
      if (req_valid_i && req_ready_o) busy = 1'b1;
      if (resp_valid_o && resp_ready_i) begin
        busy = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end else begin
      busy = 1'b0;
    end
    p_rst  = rst;
    p_rv   = resp_valid_o;
    p_crst = core_rst_o;
  end

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle; returns at a negedge.
  task automatic run_op(input logic [79:0] k, input logic [63:0] b,
                        input logic e, input int kl, input int cl,
                        input bit nev, input int hold,
                        input bit use_lit, input logic [63:0] lit);
    int n;
    st_kl = kl;
    st_cl = cl;
    st_never = nev;
    req_valid_i = 1'b1;
    key_i = k;
    block_i = b;
    enc_dec_i = e;
    #2;
    n = 0;
    while (!req_ready_o && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("req_accept_wait", 32'(n), 0);
    if (!req_ready_o) begin
      @(negedge clk);
      req_valid_i = 1'b0;
      return;
    end
    exp_q.push_back(model(k, b, e, kl, cl, nev));
    @(negedge clk);
    req_valid_i = 1'b0;
    key_i = {$urandom, $urandom, $urandom};
    block_i = {$urandom, $urandom};
    enc_dec_i = 1'($urandom_range(0, 1));
    #2;
    n = 0;
    while (!resp_valid_o && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (!resp_valid_o) begin
      chk("resp_wait_timeout", resp_valid_o, 1);
      return;
    end
    if (use_lit) chk("known_answer", block_o, lit);
    repeat (hold) @(negedge clk);
    @(negedge clk);
    resp_ready_i = 1'b1;
    @(negedge clk);
    resp_ready_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [79:0] ones;
    int n;
    ones = '1;
    rst = 1'b1;
    req_valid_i = 1'b0;
    resp_ready_i = 1'b0;
    key_i = '0;
    block_i = '0;
    enc_dec_i = 1'b0;

    chk("model_enc_k0", p_enc(80'h0, 64'h0), 64'h5579C1387B228445);
    chk("model_enc_k1", p_enc(ones, 64'h0), 64'hE72C46C0F5945049);
    chk("model_dec_k1", p_dec(ones, 64'hE72C46C0F5945049), 64'h0);

    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_op(80'h0, 64'h0, 1'b1, 4, 20, 0, 0, 1, 64'h5579C1387B228445);
    run_op(ones, 64'h0, 1'b1, 3, 5, 0, 1, 1, 64'hE72C46C0F5945049);
    run_op(ones, 64'hE72C46C0F5945049, 1'b0, 2, 7, 0, 0, 1, 64'h0);
    run_op({$urandom, $urandom, $urandom}, {$urandom, $urandom}, 1'b1,
           2, 3, 0, 20, 0, '0);
    run_op({$urandom, $urandom, $urandom}, {$urandom, $urandom}, 1'b0,
           1, 1, 0, 0, 0, '0);
    run_op({$urandom, $urandom, $urandom}, {$urandom, $urandom}, 1'b1,
           3, 0, 1, 2, 1, 64'h0);
    run_op({$urandom, $urandom, $urandom}, {$urandom, $urandom}, 1'b0,
           3, 60, 0, 0, 0, '0);
    run_op({$urandom, $urandom, $urandom}, {$urandom, $urandom}, 1'b0,
           3, 61, 0, 0, 1, 64'h0);
    run_op({$urandom, $urandom, $urandom}, {$urandom, $urandom}, 1'b1,
           5, 0, 0, 0, 0, '0);

    for (int i = 0; i < 24; i++)
      run_op({$urandom, $urandom, $urandom}, {$urandom, $urandom},
             1'($urandom_range(0, 1)), $urandom_range(1, 8),
             $urandom_range(0, 8), 0, $urandom_range(0, 3), 0, '0);

    st_kl = 2;
    st_cl = 40;
    st_never = 1'b0;
    req_valid_i = 1'b1;
    key_i = {$urandom, $urandom, $urandom};
    block_i = {$urandom, $urandom};
    enc_dec_i = 1'b1;
    exp_q.push_back(model(key_i, block_i, 1'b1, 2, 40, 0));
    @(negedge clk);
    req_valid_i = 1'b0;
    #2;
    n = 0;
    while (!core_end_key_i && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("keyend_seen", core_end_key_i, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("no_resp_after_rst", resp_valid_o, 0);

    run_op(80'h0, 64'h0, 1'b1, 6, 4, 0, 1, 1, 64'h5579C1387B228445);

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
